// File: rtl/fft_agu_param.sv
`timescale 1ns/1ps
// fft_agu_param
// Address-generation unit for an in-place radix-2 FFT of N = 2^LOG2N points.
// It walks all LOG2N butterfly stages. For every butterfly j it issues a read
// pair (rotl(2j, stage), rotl(2j+1, stage)) and a twiddle-ROM address. The
// same read addresses come back out as write addresses BF_LATENCY cycles
// later. Between stages the unit drains, so the next stage's first read
// cannot overtake the previous stage's last write.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a transform (sampled only while idle)
//   hold              suppress read issue this cycle (issue phase only)
//   busy, done        busy from the first issue cycle through the done pulse
//   stage             stage of the current read issue
//   rd_valid          rd_addr_a / rd_addr_b / twiddle_addr are valid
//   wr_en             rd_valid delayed by BF_LATENCY
//   wr_addr_a/b       rd_addr_a/b delayed by BF_LATENCY
module fft_agu_param #(
    parameter int LOG2N      = 5,
    parameter int BF_LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       rd_valid,
    output logic [LOG2N-1:0]           rd_addr_a,
    output logic [LOG2N-1:0]           rd_addr_b,
    output logic [LOG2N-2:0]           twiddle_addr,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_a,
    output logic [LOG2N-1:0]           wr_addr_b
);

    localparam int SW = $clog2(LOG2N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [LOG2N-2:0] J_LAST     = '1;
    localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(BF_LATENCY - 1);

    logic [1:0]       state;
    logic [LOG2N-2:0] j;
    logic [SW-1:0]    stage_q;
    logic [3:0]       drain_cnt;

    // Control FSM and counters.
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list holds the clock only; state uses <= throughout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            j         <= '0;
            stage_q   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ISSUE;
                        j       <= '0;
                        stage_q <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!hold) begin
                        if (j == J_LAST) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // hold is deliberately ignored here: the drain length
                    // must match the write pipeline depth exactly.
                    if (drain_cnt == DRAIN_LAST) begin
                        if (stage_q == STAGE_LAST) begin
                            state <= S_FINISH;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            j       <= '0;
                            state   <= S_ISSUE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    state   <= S_IDLE;
                    stage_q <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [LOG2N-1:0] idx_a, idx_b, rot_a, rot_b;
    logic [LOG2N-2:0] tw_mask;

    // Read-side address generation.
    // NOTE: every output of this block gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        rd_valid = (state == S_ISSUE) && !hold;
        idx_a    = {j, 1'b0};
        idx_b    = {j, 1'b1};
        // Circular left rotate by stage; a shift by LOG2N at stage 0 yields 0.
        rot_a    = (idx_a << stage_q) | (idx_a >> (LOG2N - int'(stage_q)));
        rot_b    = (idx_b << stage_q) | (idx_b >> (LOG2N - int'(stage_q)));
        // Top `stage` bits set: inverse of all-ones shifted right by stage.
        tw_mask  = ~({(LOG2N-1){1'b1}} >> stage_q);
        // Addresses are forced to 0 when not valid so idle outputs are clean.
        rd_addr_a    = rd_valid ? rot_a : '0;
        rd_addr_b    = rd_valid ? rot_b : '0;
        twiddle_addr = rd_valid ? (j & tw_mask) : '0;
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_FINISH);
    assign stage = stage_q;

    // Write replay pipeline: only the valid bits carry reset.
    logic [BF_LATENCY-1:0] vld_pipe;
    logic [LOG2N-1:0]      a_pipe [BF_LATENCY];
    logic [LOG2N-1:0]      b_pipe [BF_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_valid;
            for (int i = 1; i < BF_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // NOTE: the address stages are left unreset on purpose; they are only
    // observed when the matching valid bit is set, which reset does clear.
    always_ff @(posedge clk) begin
        a_pipe[0] <= rd_addr_a;
        b_pipe[0] <= rd_addr_b;
        for (int i = 1; i < BF_LATENCY; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end

    assign wr_en     = vld_pipe[BF_LATENCY-1];
    assign wr_addr_a = wr_en ? a_pipe[BF_LATENCY-1] : '0;
    assign wr_addr_b = wr_en ? b_pipe[BF_LATENCY-1] : '0;

endmodule

// File: tb/tb_fft_agu_param.sv
`timescale 1ns/1ps
// tb_fft_agu_param
// Randomised scoreboard bench for fft_agu_param. The driver runs a
// transaction-level model of the address sequence (stage/butterfly loops,
// rotate and mask arithmetic, per-cycle hold decisions) and queues every
// expected read, write and done event with its cycle number. Monitors pop
// and compare whenever the DUT presents the corresponding output.
module tb_fft_agu_param;

    localparam int LOG2N  = 5;
    localparam int BFL    = 4;
    localparam int NH     = 1 << (LOG2N - 1);
    localparam int SW     = $clog2(LOG2N);
    localparam int LOG2N3 = 3;
    localparam int BFL3   = 2;
    localparam int SW3    = $clog2(LOG2N3);

    logic clk, rst_n, start, hold, start3, hold3;
    logic busy, done, rd_valid, wr_en;
    logic [SW-1:0]    stage;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG2N-2:0] twiddle_addr;
    logic busy3, done3, rd_valid3, wr_en3;
    logic [SW3-1:0]    stage3;
    logic [LOG2N3-1:0] rd_addr_a3, rd_addr_b3, wr_addr_a3, wr_addr_b3;
    logic [LOG2N3-2:0] twiddle_addr3;

    fft_agu_param #(.LOG2N(LOG2N), .BF_LATENCY(BFL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
        .busy(busy), .done(done), .stage(stage), .rd_valid(rd_valid),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .twiddle_addr(twiddle_addr),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    fft_agu_param #(.LOG2N(LOG2N3), .BF_LATENCY(BFL3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .hold(hold3),
        .busy(busy3), .done(done3), .stage(stage3), .rd_valid(rd_valid3),
        .rd_addr_a(rd_addr_a3), .rd_addr_b(rd_addr_b3), .twiddle_addr(twiddle_addr3),
        .wr_en(wr_en3), .wr_addr_a(wr_addr_a3), .wr_addr_b(wr_addr_b3)
    );

    typedef struct {int cyc; int stg; int a; int b; int tw;} rd_item_t;
    typedef struct {int cyc; int a; int b;} wr_item_t;

    rd_item_t rd_q[$];
    wr_item_t wr_q[$];
    int       done_q[$];
    rd_item_t rd3_q[$];

    int cyc      = 0;
    bit exp_busy = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int n_done3  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference arithmetic taken straight from the address definitions.
    function automatic int rotl(input int x, input int s, input int n);
        return ((x << s) | (x >> (n - s))) & ((1 << n) - 1);
    endfunction

    function automatic int twid(input int j, input int s, input int n);
        int w, mask;
        w    = n - 1;
        mask = ((1 << w) - 1) & ~((1 << (w - s)) - 1);
        return j & mask;
    endfunction

    // Scoreboard monitor for the main DUT.
    always @(negedge clk) begin
        if (rst_n) begin
            rd_item_t r;
            wr_item_t w;
            int d;
            check("busy", busy, exp_busy);
            if (rd_valid) begin
                if (rd_q.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
                else begin
                    r = rd_q.pop_front();
                    check("rd_cycle", cyc, r.cyc);
                    check("rd_stage", stage, r.stg);
                    check("rd_addr_a", rd_addr_a, r.a);
                    check("rd_addr_b", rd_addr_b, r.b);
                    check("twiddle_addr", twiddle_addr, r.tw);
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) check("wr_en_unexpected", wr_en, 0);
                else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr_a", wr_addr_a, w.a);
                    check("wr_addr_b", wr_addr_b, w.b);
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", done, 0);
                else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d);
                end
            end
        end
    end

    // Order-only scoreboard for the small LOG2N=3 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            rd_item_t r;
            if (rd_valid3) begin
                if (rd3_q.size() == 0) check("dut3_rd_unexpected", rd_valid3, 0);
                else begin
                    r = rd3_q.pop_front();
                    check("dut3_stage", stage3, r.stg);
                    check("dut3_rd_addr_a", rd_addr_a3, r.a);
                    check("dut3_rd_addr_b", rd_addr_b3, r.b);
                    check("dut3_twiddle", twiddle_addr3, r.tw);
                end
            end
            if (done3) n_done3++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_stage"}, stage, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_addr_a"}, rd_addr_a, 0);
        check({tag, "_rd_addr_b"}, rd_addr_b, 0);
        check({tag, "_twiddle"}, twiddle_addr, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr_a"}, wr_addr_a, 0);
        check({tag, "_wr_addr_b"}, wr_addr_b, 0);
    endtask

    // mode 0: no hold, 1: 3-cycle hold burst mid stage 2, 2: random hold.
    // abort_at >= 0 pulls reset so the reset edge lands abort_at+1 cycles
    // after the start edge.
    task automatic run_transform(input int mode, input bit rand_start, input int abort_at);
        int  c, t, stg, rd_n, drain_left, done_cyc, burst;
        bit  issuing, h;
        @(posedge clk); #1;
        start = 1'b1; hold = 1'b0;
        c = cyc; stg = 0; rd_n = 0; issuing = 1'b1; done_cyc = -1; burst = 0; drain_left = 0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            t = cyc;
            start    = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_busy = 1'b1;
            h = 1'b0;
            if (mode == 1 && issuing && stg == 2 && rd_n == 8 && burst < 3) begin
                h = 1'b1; burst++;
            end else if (mode == 2) begin
                h = ($urandom_range(0, 3) == 0);
            end
            hold = h;
            if (t == done_cyc) break;
            if (issuing) begin
                if (!h) begin
                    rd_q.push_back('{t, stg, rotl(2*rd_n, stg, LOG2N),
                                     rotl(2*rd_n+1, stg, LOG2N), twid(rd_n, stg, LOG2N)});
                    wr_q.push_back('{t + BFL, rotl(2*rd_n, stg, LOG2N), rotl(2*rd_n+1, stg, LOG2N)});
                    rd_n++;
                    if (rd_n == NH) begin issuing = 1'b0; drain_left = BFL; end
                end
            end else begin
                drain_left--;
                if (drain_left == 0) begin
                    if (stg < LOG2N - 1) begin stg++; rd_n = 0; issuing = 1'b1; end
                    else begin done_cyc = t + 1; done_q.push_back(done_cyc); end
                end
            end
            if (abort_at >= 0 && t - c == abort_at) begin
                @(negedge clk); #1;
                rst_n = 1'b0; start = 1'b0; hold = 1'b0;
                rd_q.delete(); wr_q.delete(); done_q.delete();
                @(posedge clk); #1;
                exp_busy = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; hold = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic run3();
        for (int s = 0; s < LOG2N3; s++)
            for (int j = 0; j < (1 << (LOG2N3 - 1)); j++)
                rd3_q.push_back('{0, s, rotl(2*j, s, LOG2N3), rotl(2*j+1, s, LOG2N3), twid(j, s, LOG2N3)});
        n_done3 = 0;
        @(posedge clk); #1; start3 = 1'b1;
        @(posedge clk); #1; start3 = 1'b0;
        repeat (LOG2N3 * ((1 << (LOG2N3 - 1)) + BFL3) + 6) @(posedge clk);
        check("dut3_rd_left", rd3_q.size(), 0);
        check("dut3_done_count", n_done3, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; start3 = 1'b0; hold3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_transform(0, 1'b0, -1);
        run_transform(1, 1'b1, -1);
        run_transform(2, 1'b1, -1);
        run_transform(2, 1'b0, -1);
        run_transform(0, 1'b0, 39);
        repeat (30) @(posedge clk);
        run_transform(0, 1'b0, -1);
        run3();

        repeat (8) @(posedge clk);
        check("rd_queue_left", rd_q.size(), 0);
        check("wr_queue_left", wr_q.size(), 0);
        check("done_queue_left", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_agu_param.md
# fft_agu_param

Parametrised address-generation unit for the in-place radix-2 FFT datapath. It sequences all LOG2N butterfly stages of an N = 2^LOG2N point transform. For each butterfly it issues a pair of read addresses for the two data memories and a twiddle-ROM address. It then replays the same addresses as write addresses after a configurable butterfly latency, so writes stay aligned with the butterfly output. It sits between the top-level control (start/done) and the butterfly/memory datapath, and adds start/done handshaking, an issue-hold input and inter-stage hazard draining.

## Interface
- LOG2N, default 5, log2 of transform size; legal range 2..10; N = 2^LOG2N.
- BF_LATENCY, default 4, cycles from a read issue to the matching write; legal range 1..15.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request transform; sampled only in IDLE.
- hold  input  1  while 1 in ISSUE, no new read is issued; pipeline keeps advancing.
- busy  output  1  1 from cycle after accepted start until done pulse (inclusive).
- done  output  1  one-cycle pulse after the final write.
- stage  output  $clog2(LOG2N)  stage of the current read issue.
- rd_valid  output  1  read addresses valid this cycle.
- rd_addr_a  output  LOG2N  rotl(2j, stage) within LOG2N bits.
- rd_addr_b  output  LOG2N  rotl(2j+1, stage).
- twiddle_addr  output  LOG2N-1  j AND mask(stage); mask = top `stage` bits set, others 0.
- wr_en  output  1  rd_valid delayed exactly BF_LATENCY cycles.
- wr_addr_a, wr_addr_b  output  LOG2N  rd_addr_a/b delayed exactly BF_LATENCY cycles.

## Operation
- The index counter j is LOG2N-1 bits wide and runs 0..N/2-1 within each stage. The stage counter runs 0..LOG2N-1.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: busy=0, rd_valid=0. On start=1, go to ISSUE with j=0 and stage=0.
- ISSUE: each cycle with hold=0, assert rd_valid and increment j.
  - A hold=1 cycle outputs rd_valid=0 and leaves j unchanged.
  - After issuing j=N/2-1, go to DRAIN.
- DRAIN: last for BF_LATENCY cycles, with rd_valid=0.
  - The next stage's first read must be issued strictly after the previous stage's final write.
  - Then, if stage < LOG2N-1: increment stage, set j=0, return to ISSUE.
  - Otherwise go to FINISH.
- FINISH: one cycle; done=1 and busy=1. Then go to IDLE.
- Hold during DRAIN has no effect on the drain count.
- start while busy is ignored; it is not queued.
- Rotate is a circular left rotate by `stage` of the LOG2N-bit value. At stage 0 the addresses are 2j and 2j+1.
- Twiddle mask per stage, with W = LOG2N-1 bits:
  - Stage 0 mask is all zeros.
  - Stage s mask has bits W-1..W-s set.
  - Stage LOG2N-1 mask is all ones.
- The write pipeline is a BF_LATENCY-deep shift register of {valid, addr_a, addr_b}. Only the valid bit requires reset.

## Timing
- Reset (rst_n=0 at an edge): FSM goes to IDLE, the counters and every pipeline valid bit clear to 0, and all outputs read 0 the next cycle.
- Reset mid-transform aborts the transform: no wr_en, no done afterward.
- start accepted at edge 0: first rd_valid in cycle 1, and busy=1 from cycle 1.
- Each stage takes N/2 + BF_LATENCY cycles when there is no hold. Each hold cycle in ISSUE adds one cycle.
- Final write occurs in cycle LOG2N*(N/2+BF_LATENCY). done occurs in the next cycle, and busy drops after it.
  - Defaults: final write in cycle 100, done in cycle 101.
- A new start may be accepted in the cycle after done.
- wr_en never asserts in IDLE except for the pipeline tail, which cannot exist because FINISH follows DRAIN.

## Test plan
- LOG2N=5, BF_LATENCY=4, start pulse, no hold -> 80 rd_valid and 80 wr_en cycles; done in cycle 101.
  - Stage 0, j=3: rd_addr_a=6, rd_addr_b=7, twiddle_addr=0.
- LOG2N=3, stage 1 -> j=1 gives rd 4/6, twiddle 0; j=3 gives rd 5/7, twiddle 2.
  - Stage 2, j=1: rd 1/5, twiddle 1.
- hold=1 for 3 cycles mid-stage 2 -> exactly 3 cycles of rd_valid=0, and the j sequence is unchanged.
  - done is delayed by 3 cycles, and wr_addr equals rd_addr delayed 4 cycles throughout.
- Stage boundary -> the first rd_valid of stage s+1 occurs exactly one cycle after the last wr_en of stage s.
- start reasserted while busy -> ignored; only one done pulse results.
- rst_n=0 at cycle 40 -> all outputs 0 the next cycle, no further wr_en/done; a fresh start then yields done 101 cycles later.
